// File: rtl/phy_pkg.sv
// phy_pkg: shared 802.11a PHY rate codes, coded-bit sizes and interleaver controller states
package phy_pkg;
  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_18 = 4'b0111;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1011;
  localparam logic [3:0] RATE_48 = 4'b0001;
  localparam logic [3:0] RATE_54 = 4'b0011;
  localparam logic [8:0] NCBPS_48  = 9'd48;
  localparam logic [8:0] NCBPS_96  = 9'd96;
  localparam logic [8:0] NCBPS_192 = 9'd192;
  localparam logic [8:0] NCBPS_288 = 9'd288;
  typedef enum logic [2:0] {IDLE, CFG, GAP, FEED, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [8:0] ncbps;
    logic       legal;
  } rate_info_t;
  function automatic rate_info_t rate_info(input logic [3:0] rate);
    rate_info_t r;
    r.legal = 1'b1;
    case (rate)
      RATE_6, RATE_9:   r.ncbps = NCBPS_48;
      RATE_12, RATE_18: r.ncbps = NCBPS_96;
      RATE_24, RATE_36: r.ncbps = NCBPS_192;
      RATE_48, RATE_54: r.ncbps = NCBPS_288;
      default: begin
        r.ncbps = '0;
        r.legal = 1'b0;
      end
    endcase
    return r;
  endfunction
endpackage

// File: rtl/interleaver_ctrl_if.sv
// interleaver_ctrl_if: frame request, upstream bit handshake and interleaver-side signals
interface interleaver_ctrl_if #(parameter int SYM_W = 10);
  logic             iStart;
  logic [3:0]       iRate;
  logic [SYM_W-1:0] iNumSym;
  logic             iBitValid;
  logic             iBit;
  logic             oBitReady;
  logic             oIntRateEN;
  logic [3:0]       oIntRate;
  logic             oIntEN;
  logic             oIntData;
  logic             iIntValid;
  logic             oBusy;
  logic             oSymDone;
  logic             oDone;
  logic             oErr;
  modport master (
    input  iStart, iRate, iNumSym, iBitValid, iBit, iIntValid,
    output oBitReady, oIntRateEN, oIntRate, oIntEN, oIntData, oBusy, oSymDone, oDone, oErr
  );
  modport slave (
    output iStart, iRate, iNumSym, iBitValid, iBit, iIntValid,
    input  oBitReady, oIntRateEN, oIntRate, oIntEN, oIntData, oBusy, oSymDone, oDone, oErr
  );
endinterface

// File: rtl/rate_lut.sv
// rate_lut: combinational 802.11a RATE -> coded bits per symbol with legality flag
module rate_lut
  import phy_pkg::*;
(
  input  logic [3:0] iRate,
  output logic [8:0] oNcbps,
  output logic       oLegal
);
  rate_info_t info;
  assign info   = rate_info(iRate);
  assign oNcbps = info.ncbps;
  assign oLegal = info.legal;
endmodule

// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl: configures the TX interleaver, feeds NumSym*N_CBPS coded bits into it
// and counts its output bits to signal frame completion or a drain timeout.
module interleaver_ctrl
  import phy_pkg::*;
#(
  parameter int SYM_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input logic               iClk,
  input logic               iRst_n,
  interleaver_ctrl_if.master bus
);
  localparam int TOT_W = SYM_W + 9;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  state_t           state;
  logic [3:0]       rate_q;
  logic [8:0]       ncbps, lut_ncbps;
  logic             lut_legal;
  logic [SYM_W-1:0] num_sym, sym_cnt;
  logic [8:0]       bit_cnt;
  logic [TOT_W-1:0] tot, out_cnt, out_nxt;
  logic [WD_W-1:0]  wd;
  logic             xfer, sym_end, last_bit, cnt_en, sym_done, err;
  rate_lut u_rate_lut (.iRate(bus.iRate), .oNcbps(lut_ncbps), .oLegal(lut_legal));
  assign xfer     = state == FEED && bus.iBitValid;
  assign sym_end  = bit_cnt == ncbps - 9'd1;
  assign last_bit = xfer && sym_end && sym_cnt == num_sym - SYM_W'(1);
  assign cnt_en   = (state == FEED || state == DRAIN) && bus.iIntValid;
  assign out_nxt  = out_cnt + TOT_W'(cnt_en);
  assign bus.oBitReady  = state == FEED;
  assign bus.oIntEN     = xfer;
  assign bus.oIntData   = xfer && bus.iBit;
  assign bus.oIntRateEN = state == CFG;
  assign bus.oIntRate   = rate_q;
  assign bus.oBusy      = state != IDLE;
  assign bus.oDone      = state == DONE;
  assign bus.oSymDone   = sym_done;
  assign bus.oErr       = err;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      rate_q   <= '0;
      ncbps    <= '0;
      num_sym  <= '0;
      sym_cnt  <= '0;
      bit_cnt  <= '0;
      tot      <= '0;
      out_cnt  <= '0;
      wd       <= '0;
      sym_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      sym_done <= xfer && sym_end;
      err      <= 1'b0;
      if (cnt_en) out_cnt <= out_nxt;
      case (state)
        IDLE: if (bus.iStart) begin
          if (lut_legal && bus.iNumSym != '0) begin
            state   <= CFG;
            rate_q  <= bus.iRate;
            ncbps   <= lut_ncbps;
            num_sym <= bus.iNumSym;
          end else begin
            err <= 1'b1;
          end
        end
        CFG: begin
          state   <= GAP;
          tot     <= TOT_W'(num_sym) * TOT_W'(ncbps);
          sym_cnt <= '0;
          bit_cnt <= '0;
          out_cnt <= '0;
        end
        GAP: state <= FEED;
        FEED: begin
          wd <= WD_W'(1);
          if (xfer) begin
            bit_cnt <= sym_end ? '0 : bit_cnt + 9'd1;
            if (sym_end) sym_cnt <= sym_cnt + SYM_W'(1);
            if (last_bit) state <= DRAIN;
          end
        end
        DRAIN: begin
          // wd holds the number of cycles elapsed since the last interleaver output bit
          if (out_nxt >= tot) begin
            state <= DONE;
          end else if (bus.iIntValid) begin
            wd <= WD_W'(1);
          end else if (wd >= WD_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
